// File: rtl/e_bus_sequencer_if.sv
// Handshake and peripheral bus between a requester, the E-bus sequencer and a 6800-style CIA.
// The sequencer connects through the slave modport; the requester/E source uses master.
interface e_bus_sequencer_if #(
    parameter int unsigned DW = 8
);
    logic          e;
    logic          req;
    logic          rd;
    logic [DW-1:0] cia_dout;
    logic          eclk;
    logic          e_lock;
    logic          vma;
    logic          cia_strobe;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output e, req, rd, cia_dout,
        input  eclk, e_lock, vma, cia_strobe, ack, rdata
    );

    modport slave (
        input  e, req, rd, cia_dout,
        output eclk, e_lock, vma, cia_strobe, ack, rdata
    );
endinterface

// File: rtl/e_bus_sequencer.sv
// Tracks E phase from the one-cycle e pulse, rebuilds the E level and sequences
// synchronous peripheral cycles aligned to full E periods.
module e_bus_sequencer #(
    parameter int unsigned DW = 8
) (
    input  logic               clk,
    input  logic               reset,
    e_bus_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StAccess,
        StDone,
        StRelease
    } state_t;

    logic [3:0]    r_phase;
    logic          r_e_lock;
    state_t        r_state;
    state_t        w_state_d;
    logic [DW-1:0] r_rdata;
    logic          w_phase_last;
    logic          w_strobe;

    assign w_phase_last = (r_phase == 4'd9);

    // A pulse always resyncs the counter; lock only survives if it lands on phase 9.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase  <= 4'd0;
            r_e_lock <= 1'b0;
        end else begin
            if (bus.e || w_phase_last) begin
                r_phase <= 4'd0;
            end else begin
                r_phase <= r_phase + 4'd1;
            end

            if (bus.e) begin
                r_e_lock <= w_phase_last;
            end else if (w_phase_last) begin
                r_e_lock <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_strobe  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req) begin
                    w_state_d = StSync;
                end
            end
            StSync: begin
                if (!bus.req) begin
                    w_state_d = StIdle;
                end else if (bus.e && r_e_lock) begin
                    w_state_d = StAccess;
                end
            end
            StAccess: begin
                // Requester deassertion is ignored here; only loss of lock aborts.
                if (bus.e && r_e_lock) begin
                    w_strobe  = 1'b1;
                    w_state_d = StDone;
                end else if (!r_e_lock) begin
                    w_state_d = StSync;
                end
            end
            StDone: begin
                w_state_d = StRelease;
            end
            StRelease: begin
                if (!bus.req) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_strobe && bus.rd) begin
            r_rdata <= bus.cia_dout;
        end
    end

    assign bus.e_lock     = r_e_lock;
    assign bus.eclk       = r_e_lock && (r_phase >= 4'd6);
    assign bus.vma        = (r_state == StAccess);
    assign bus.cia_strobe = w_strobe;
    assign bus.ack        = (r_state == StDone);
    assign bus.rdata      = r_rdata;

endmodule

// File: tb/tb_e_bus_sequencer.sv
// Self-checking bench for e_bus_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a request-lifecycle reference model.
module tb_e_bus_sequencer;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    e_bus_sequencer_if #(.DW(DW)) bus ();

    e_bus_sequencer #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e_base  = 0;

    // Reference model: phase from cycles since the last pulse, plus request lifecycle flags.
    int       m_anchor;
    bit       m_lock;
    bit       m_wait;
    bit       m_acc;
    bit       m_ack;
    bit       m_hold;
    logic [7:0] m_rdata;

    int c_vma, c_strobe, c_ack, c_eclk, last_ack_cyc;
    int first_lock, first_eclk;
    bit saw_unlock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int m_phase();
        return (cyc - m_anchor) % 10;
    endfunction

    function automatic int nom_phase();
        return (cyc - e_base + 1000) % 10;
    endfunction

    function automatic bit e_nom();
        return nom_phase() == 9;
    endfunction

    task automatic model_reset();
        m_anchor = cyc;
        m_lock   = 1'b0;
        m_wait   = 1'b0;
        m_acc    = 1'b0;
        m_ack    = 1'b0;
        m_hold   = 1'b0;
        m_rdata  = 8'h00;
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge, advances the model.
    task automatic step(input bit ie, input bit ireq, input bit ird, input logic [7:0] idout);
        int ph;
        bit nlock;
        bus.e        = ie;
        bus.req      = ireq;
        bus.rd       = ird;
        bus.cia_dout = idout;
        @(negedge clk);
        ph = m_phase();
        check("e_lock", bus.e_lock, m_lock);
        check("eclk", bus.eclk, m_lock && (ph >= 6));
        check("vma", bus.vma, m_acc);
        check("cia_strobe", bus.cia_strobe, m_acc && ie && m_lock);
        check("ack", bus.ack, m_ack);
        check("rdata", bus.rdata, m_rdata);

        if (bus.vma) c_vma++;
        if (bus.cia_strobe) c_strobe++;
        if (bus.eclk) c_eclk++;
        if (bus.ack) begin
            c_ack++;
            last_ack_cyc = cyc;
        end
        if (!bus.e_lock) saw_unlock = 1'b1;
        if (bus.e_lock && first_lock < 0) first_lock = cyc;
        if (bus.eclk && first_eclk < 0) first_eclk = cyc;

        nlock = m_lock;
        if (ie) nlock = (ph == 9);
        else if (ph == 9) nlock = 1'b0;

        if (m_ack) begin
            m_ack  = 1'b0;
            m_hold = 1'b1;
        end else if (m_hold) begin
            if (!ireq) m_hold = 1'b0;
        end else if (m_acc) begin
            if (ie && m_lock) begin
                if (ird) m_rdata = idout;
                m_acc = 1'b0;
                m_ack = 1'b1;
            end else if (!m_lock) begin
                m_acc  = 1'b0;
                m_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (!ireq) begin
                m_wait = 1'b0;
            end else if (ie && m_lock) begin
                m_wait = 1'b0;
                m_acc  = 1'b1;
            end
        end else if (ireq) begin
            m_wait = 1'b1;
        end

        if (ie) m_anchor = cyc + 1;
        m_lock = nlock;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic nominal(input int n, input bit ireq, input bit ird, input logic [7:0] d);
        for (int i = 0; i < n; i++) step(e_nom(), ireq, ird, d);
    endtask

    task automatic go_phase(input int p);
        for (int i = 0; i < 10 && nom_phase() != p; i++) step(e_nom(), 1'b0, 1'b0, 8'h00);
    endtask

    task automatic hold_until_ack(input bit ird, input logic [7:0] d, input int budget,
                                  output int lat);
        int c0;
        int rc;
        c0 = c_ack;
        rc = cyc;
        for (int i = 0; i < budget; i++) begin
            step(e_nom(), 1'b1, ird, d);
            if (c_ack != c0) break;
        end
        check("ack_count", c_ack - c0, 1);
        lat = last_ack_cyc - rc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_eclk"}, bus.eclk, 0);
        check({tag, "_e_lock"}, bus.e_lock, 0);
        check({tag, "_vma"}, bus.vma, 0);
        check({tag, "_strobe"}, bus.cia_strobe, 0);
        check({tag, "_ack"}, bus.ack, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
    endtask

    // Entered at posedge+1; reset lands mid-cycle and is released after one edge.
    task automatic async_reset_mid();
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        bus.req = 1'b0;
        bus.e   = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        model_reset();
        e_base = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p;
        int exp_lat;
        bit r_req;
        bit r_rd;
        int r_c0;
        bit shifted;
        bit ie;

        bus.e = 1'b0;
        bus.req = 1'b0;
        bus.rd = 1'b0;
        bus.cia_dout = 8'h00;
        first_lock = -1;
        first_eclk = -1;
        c_vma = 0; c_strobe = 0; c_ack = 0; c_eclk = 0; last_ack_cyc = -1;
        saw_unlock = 1'b0;

        #1 reset = 1'b1;
        #2 check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        e_base = 0;
        model_reset();

        // Lock acquisition with pulses at 9, 19, 29.
        nominal(30, 1'b0, 1'b0, 8'h00);
        check("first_lock", first_lock, 10);
        check("first_eclk", first_eclk, 16);
        check("eclk_cycles", c_eclk, 8);

        // Read cycle raised at phase 0.
        c_vma = 0; c_strobe = 0;
        hold_until_ack(1'b1, 8'hA5, 40, lat);
        check("read_latency", lat, 20);
        check("read_rdata", bus.rdata, 8'hA5);
        check("read_vma_len", c_vma, 10);
        check("read_strobes", c_strobe, 1);
        nominal(2, 1'b0, 1'b0, 8'h00);

        // Write cycle raised at phase 8, then req held high after ack.
        go_phase(8);
        c_vma = 0; c_strobe = 0;
        hold_until_ack(1'b0, 8'h3C, 40, lat);
        check("write_latency", lat, 12);
        check("write_strobes", c_strobe, 1);
        c_vma = 0;
        nominal(25, 1'b1, 1'b0, 8'h5A);
        check("held_req_no_vma", c_vma, 0);
        check("write_rdata_kept", bus.rdata, 8'hA5);
        nominal(3, 1'b0, 1'b0, 8'h00);

        // Abort while waiting for alignment.
        go_phase(0);
        c_vma = 0; c_strobe = 0; c_ack = 0;
        nominal(4, 1'b1, 1'b1, 8'hFF);
        nominal(20, 1'b0, 1'b0, 8'h00);
        check("abort_vma", c_vma, 0);
        check("abort_strobe", c_strobe, 0);
        check("abort_ack", c_ack, 0);

        // Phase disturbance during access: pulse shifted 3 cycles late.
        go_phase(0);
        c_vma = 0; c_strobe = 0; c_ack = 0; saw_unlock = 1'b0; shifted = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(e_nom(), 1'b1, 1'b1, 8'h77);
            if (!shifted && c_vma > 0) begin
                e_base += 3;
                shifted = 1'b1;
            end
            if (c_ack != 0) break;
        end
        check("disturb_ack", c_ack, 1);
        check("disturb_strobe", c_strobe, 1);
        check("disturb_unlock", saw_unlock, 1);
        check("disturb_rdata", bus.rdata, 8'h77);
        nominal(2, 1'b0, 1'b0, 8'h00);

        // Async reset mid-access.
        go_phase(0);
        c_vma = 0;
        for (int i = 0; i < 20 && c_vma < 3; i++) step(e_nom(), 1'b1, 1'b1, 8'h11);
        async_reset_mid();
        c_ack = 0;
        nominal(30, 1'b0, 1'b0, 8'h00);
        check("post_reset_ack", c_ack, 0);

        // Random request phases; latency follows from where the next pulse lands.
        for (int k = 0; k < 8; k++) begin
            nominal($urandom_range(0, 9), 1'b0, 1'b0, 8'h00);
            p = nom_phase();
            exp_lat = ((p < 9) ? (9 - p) : 10) + 11;
            hold_until_ack(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 40, lat);
            check("rand_latency", lat, exp_lat);
            nominal($urandom_range(0, 2), 1'b1, 1'b0, 8'h00);
            nominal(1, 1'b0, 1'b0, 8'h00);
        end

        // Random traffic with jitter and stray/missing pulses.
        r_req = 1'b0;
        r_rd = 1'b0;
        r_c0 = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) e_base += $urandom_range(1, 4);
            ie = e_nom();
            if ($urandom_range(0, 59) == 0) ie = !ie;
            if (!r_req) begin
                if ($urandom_range(0, 5) == 0) begin
                    r_req = 1'b1;
                    r_rd = 1'($urandom_range(0, 1));
                    r_c0 = c_ack;
                end
            end else if (c_ack != r_c0) begin
                if ($urandom_range(0, 1) == 0) r_req = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                r_req = 1'b0;
            end
            step(ie, r_req, r_rd, 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
